// File: rtl/reg_bus_master.sv
// Byte-wide register bus initiator: takes one read/write request at a time and sequences
// SETUP, STROBE and HOLD phases on the peripheral bus, returning a one-cycle response.
module reg_bus_master #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned USE_DTACK  = 0,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_wdata,
  output logic              rsp_valid,
  output logic [7:0]        rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_sel,
  output logic              bus_ds,
  output logic              bus_rw,
  output logic [7:0]        bus_dout,
  input  logic [7:0]        bus_din,
  input  logic              bus_dtack
);

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

  state_e     state_q;
  logic       write_q;
  logic [7:0] cnt_q;
  logic       strobe_done;
  logic       strobe_err;

  assign req_ready = (state_q == StIdle);

  // A dtack on the same edge as the timeout wins, so it is tested first.
  always_comb begin
    strobe_done = 1'b0;
    strobe_err  = 1'b0;
    if (USE_DTACK != 0) begin
      if (bus_dtack) begin
        strobe_done = 1'b1;
      end else if (cnt_q == 8'(TIMEOUT)) begin
        strobe_done = 1'b1;
        strobe_err  = 1'b1;
      end
    end else begin
      strobe_done = (cnt_q == 8'(STROBE_CYC));
    end
  end

  // All bus outputs are registers so peripherals sampling on negedge never see a glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      write_q   <= 1'b0;
      cnt_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      bus_sel   <= 1'b0;
      bus_ds    <= 1'b1;
      bus_rw    <= 1'b1;
      bus_addr  <= '0;
      bus_dout  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            write_q  <= req_write;
            bus_sel  <= 1'b1;
            bus_ds   <= 1'b1;
            bus_rw   <= ~req_write;
            bus_addr <= req_addr;
            bus_dout <= req_write ? req_wdata : 8'h00;
            state_q  <= StSetup;
          end
        end
        StSetup: begin
          bus_ds  <= 1'b0;
          cnt_q   <= 8'd1;
          state_q <= StStrobe;
        end
        StStrobe: begin
          if (strobe_done) begin
            bus_ds    <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_err   <= strobe_err;
            rsp_rdata <= (write_q || strobe_err) ? 8'h00 : bus_din;
            state_q   <= StHold;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StHold: begin
          bus_sel  <= 1'b0;
          bus_rw   <= 1'b1;
          bus_addr <= '0;
          bus_dout <= '0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_master.sv
// Directed bench for reg_bus_master: a fixed-strobe instance with an 8-bit config slave at
// 0x10, and a dtack-mode instance (TIMEOUT=4) with a bench-driven acknowledge.
module tb_reg_bus_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // Fixed-strobe instance
  logic       a_req_valid, a_req_ready, a_req_write;
  logic [7:0] a_req_addr, a_req_wdata;
  logic       a_rsp_valid, a_rsp_err;
  logic [7:0] a_rsp_rdata;
  logic [7:0] a_bus_addr, a_bus_dout, a_bus_din;
  logic       a_bus_sel, a_bus_ds, a_bus_rw;
  logic       a_bus_dtack;

  // Dtack-mode instance
  logic       b_req_valid, b_req_ready, b_req_write;
  logic [7:0] b_req_addr, b_req_wdata;
  logic       b_rsp_valid, b_rsp_err;
  logic [7:0] b_rsp_rdata;
  logic [7:0] b_bus_addr, b_bus_dout, b_bus_din;
  logic       b_bus_sel, b_bus_ds, b_bus_rw;
  logic       b_bus_dtack;
  logic [7:0] b_din_val;

  reg_bus_master u_dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .bus_addr(a_bus_addr), .bus_sel(a_bus_sel), .bus_ds(a_bus_ds), .bus_rw(a_bus_rw),
    .bus_dout(a_bus_dout), .bus_din(a_bus_din), .bus_dtack(a_bus_dtack)
  );

  reg_bus_master #(.ADDR_W(8), .STROBE_CYC(2), .USE_DTACK(1), .TIMEOUT(4)) u_dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .bus_addr(b_bus_addr), .bus_sel(b_bus_sel), .bus_ds(b_bus_ds), .bus_rw(b_bus_rw),
    .bus_dout(b_bus_dout), .bus_din(b_bus_din), .bus_dtack(b_bus_dtack)
  );

  // Config slave: samples on negedge while selected with ds low
  logic [7:0] cfg = 8'h00;
  always @(negedge clk)
    if (a_bus_sel && !a_bus_ds && !a_bus_rw && a_bus_addr == 8'h10) cfg <= a_bus_dout;
  assign a_bus_din = (a_bus_sel && a_bus_addr == 8'h10) ? cfg : 8'h00;
  assign b_bus_din = b_bus_sel ? b_din_val : 8'h00;

  int sel_viol_a = 0;
  int sel_viol_b = 0;
  always @(negedge clk) begin
    if (!a_bus_ds && !a_bus_sel) sel_viol_a++;
    if (!b_bus_ds && !b_bus_sel) sel_viol_b++;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic [7:0] exp_cfg;
  } vec_a_t;

  typedef struct {
    logic       early;     // dtack also high during SETUP (must be ignored)
    int         dtack_at;  // strobe cycle carrying dtack, 0 = never
    logic [7:0] din;
    int         exp_ds;
    logic       exp_err;
    logic [7:0] exp_rdata;
  } vec_b_t;

  vec_a_t va[7];
  vec_b_t vb[5];

  // Starts at a negedge in IDLE, returns at the negedge of the HOLD cycle.
  task automatic run_a(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                       output int lat, output int ds_low, output int bad,
                       output logic [7:0] rdata, output logic err);
    lat = 0; ds_low = 0; bad = 0; rdata = 8'hxx; err = 1'bx;
    a_req_valid = 1'b1; a_req_write = wr; a_req_addr = addr; a_req_wdata = wdata;
    check("a_ready_before_accept", {31'd0, a_req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 1'b0; a_req_write = ~wr; a_req_addr = 8'hFF; a_req_wdata = 8'hFF;
    for (int k = 1; k <= 40; k++) begin
      if (!a_bus_ds) ds_low++;
      if (!a_bus_sel || a_bus_rw !== ~wr || a_bus_addr !== addr ||
          a_bus_dout !== (wr ? wdata : 8'h00) || a_req_ready) bad++;
      if (a_rsp_valid) begin
        lat = k; rdata = a_rsp_rdata; err = a_rsp_err;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_b(input logic early, input int dtack_at,
                       output int lat, output int ds_low, output int bad,
                       output logic [7:0] rdata, output logic err);
    lat = 0; ds_low = 0; bad = 0; rdata = 8'hxx; err = 1'bx;
    b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 8'h42; b_req_wdata = 8'h99;
    b_bus_dtack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    b_req_valid = 1'b0; b_req_addr = 8'h00;
    for (int k = 1; k <= 40; k++) begin
      if (!b_bus_sel || b_bus_rw !== 1'b1 || b_bus_addr !== 8'h42) bad++;
      if (b_rsp_valid) begin
        lat = k; rdata = b_rsp_rdata; err = b_rsp_err;
        break;
      end
      if (!b_bus_ds) begin
        ds_low++;
        b_bus_dtack = (ds_low == dtack_at);
      end else begin
        b_bus_dtack = early;
      end
      @(negedge clk);
    end
    b_bus_dtack = 1'b0;
  endtask

  int lat, ds_low, bad;
  logic [7:0] rdata;
  logic err;
  int acc0, acc1, rsp0, nacc, nrsp, busy_rdy;
  logic just_acc;
  logic [7:0] rdata2;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    va[0] = '{1'b1, 8'h10, 8'h03, 8'h00, 8'h03};
    va[1] = '{1'b0, 8'h10, 8'h00, 8'h03, 8'h03};
    va[2] = '{1'b1, 8'h10, 8'h5A, 8'h00, 8'h5A};
    va[3] = '{1'b0, 8'h10, 8'h00, 8'h5A, 8'h5A};
    va[4] = '{1'b1, 8'h20, 8'h77, 8'h00, 8'h5A};
    va[5] = '{1'b0, 8'h20, 8'h00, 8'h00, 8'h5A};
    va[6] = '{1'b0, 8'h10, 8'h00, 8'h5A, 8'h5A};

    vb[0] = '{1'b0, 3, 8'hA5, 3, 1'b0, 8'hA5};
    vb[1] = '{1'b0, 0, 8'h3C, 4, 1'b1, 8'h00};
    vb[2] = '{1'b0, 4, 8'h5A, 4, 1'b0, 8'h5A};
    vb[3] = '{1'b1, 2, 8'hC3, 2, 1'b0, 8'hC3};
    vb[4] = '{1'b1, 0, 8'h77, 4, 1'b1, 8'h00};

    reset = 1'b1;
    a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = 8'h00; a_req_wdata = 8'h00;
    a_bus_dtack = 1'b0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = 8'h00; b_req_wdata = 8'h00;
    b_bus_dtack = 1'b0; b_din_val = 8'h00;
    repeat (3) @(negedge clk);

    check("rst_req_ready", {31'd0, a_req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    check("rst_rsp_rdata", {24'd0, a_rsp_rdata}, 32'd0);
    check("rst_rsp_err",   {31'd0, a_rsp_err},   32'd0);
    check("rst_bus_sel",   {31'd0, a_bus_sel},   32'd0);
    check("rst_bus_ds",    {31'd0, a_bus_ds},    32'd1);
    check("rst_bus_rw",    {31'd0, a_bus_rw},    32'd1);
    check("rst_bus_addr",  {24'd0, a_bus_addr},  32'd0);
    check("rst_bus_dout",  {24'd0, a_bus_dout},  32'd0);
    check("rst_b_ready",   {31'd0, b_req_ready}, 32'd1);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_a(va[i].wr, va[i].addr, va[i].wdata, lat, ds_low, bad, rdata, err);
      check($sformatf("a%0d_latency", i), lat, 32'd4);
      check($sformatf("a%0d_ds_low_cycles", i), ds_low, 32'd2);
      check($sformatf("a%0d_bus_shape", i), bad, 32'd0);
      check($sformatf("a%0d_rdata", i), {24'd0, rdata}, {24'd0, va[i].exp_rdata});
      check($sformatf("a%0d_err", i), {31'd0, err}, 32'd0);
      @(negedge clk);
      check($sformatf("a%0d_single_pulse", i), {31'd0, a_rsp_valid}, 32'd0);
      check($sformatf("a%0d_idle_ready", i), {31'd0, a_req_ready}, 32'd1);
      check($sformatf("a%0d_idle_sel", i), {31'd0, a_bus_sel}, 32'd0);
      check($sformatf("a%0d_rdata_held", i), {24'd0, a_rsp_rdata}, {24'd0, va[i].exp_rdata});
      check($sformatf("a%0d_slave_cfg", i), {24'd0, cfg}, {24'd0, va[i].exp_cfg});
    end

    // Two queued requests with req_valid held high
    acc0 = -1; acc1 = -1; rsp0 = -1; nacc = 0; nrsp = 0; busy_rdy = 0;
    just_acc = 1'b0; rdata2 = 8'hxx;
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 8'h10; a_req_wdata = 8'h11;
    for (int c = 0; c < 20; c++) begin
      if (just_acc) begin
        if (nacc == 1) begin
          a_req_write = 1'b0; a_req_addr = 8'h10; a_req_wdata = 8'h00;
        end else begin
          a_req_valid = 1'b0;
        end
        just_acc = 1'b0;
      end
      if (a_rsp_valid) begin
        if (nrsp == 0) rsp0 = c;
        else rdata2 = a_rsp_rdata;
        nrsp++;
      end
      if (nacc == 1 && c > acc0 && c <= acc0 + 4 && a_req_ready) busy_rdy++;
      if (a_req_ready && a_req_valid) begin
        if (nacc == 0) acc0 = c;
        else acc1 = c;
        nacc++;
        just_acc = 1'b1;
      end
      @(negedge clk);
    end
    check("busy_ready_low", busy_rdy, 32'd0);
    check("busy_rsp_count", nrsp, 32'd2);
    check("busy_accept_spacing", acc1 - acc0, 32'd5);
    check("busy_accept_after_rsp", acc1 - rsp0, 32'd1);
    check("busy_read_back", {24'd0, rdata2}, 32'h11);

    // Reset during STROBE of a write
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 8'h10; a_req_wdata = 8'hEE;
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_in_strobe", {31'd0, a_bus_ds}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_sel", {31'd0, a_bus_sel}, 32'd0);
    check("rst_mid_ds", {31'd0, a_bus_ds}, 32'd1);
    check("rst_mid_rw", {31'd0, a_bus_rw}, 32'd1);
    check("rst_mid_ready", {31'd0, a_req_ready}, 32'd1);
    nrsp = 0;
    for (int c = 0; c < 6; c++) begin
      if (a_rsp_valid) nrsp++;
      @(negedge clk);
    end
    check("rst_mid_no_rsp", nrsp, 32'd0);
    check("rst_mid_slave", {24'd0, cfg}, 32'hEE);
    run_a(1'b0, 8'h10, 8'h00, lat, ds_low, bad, rdata, err);
    check("post_rst_rdata", {24'd0, rdata}, 32'hEE);
    check("post_rst_latency", lat, 32'd4);
    @(negedge clk);

    // Dtack-mode instance
    for (int i = 0; i < 5; i++) begin
      b_din_val = vb[i].din;
      run_b(vb[i].early, vb[i].dtack_at, lat, ds_low, bad, rdata, err);
      check($sformatf("b%0d_ds_low_cycles", i), ds_low, vb[i].exp_ds);
      check($sformatf("b%0d_latency", i), lat, vb[i].exp_ds + 2);
      check($sformatf("b%0d_bus_shape", i), bad, 32'd0);
      check($sformatf("b%0d_rdata", i), {24'd0, rdata}, {24'd0, vb[i].exp_rdata});
      check($sformatf("b%0d_err", i), {31'd0, err}, {31'd0, vb[i].exp_err});
      @(negedge clk);
      check($sformatf("b%0d_single_pulse", i), {31'd0, b_rsp_valid}, 32'd0);
      check($sformatf("b%0d_err_held", i), {31'd0, b_rsp_err}, {31'd0, vb[i].exp_err});
    end

    check("a_ds_never_without_sel", sel_viol_a, 32'd0);
    check("b_ds_never_without_sel", sel_viol_b, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bus_master.md
Name: reg_bus_master

Overview:
- Bus initiator for the byte-wide CPU-register peripheral interface (sel / active-low ds / rw / din / dout).
- Issues single register reads and writes on behalf of a non-CPU agent, e.g. IO-controller-driven config or a test sequencer.
- Accepts one request at a time over a valid/ready handshake.
- Sequences setup, strobe and hold phases on the register bus, then returns read data or completion status as a one-cycle response pulse.
- Drives outputs on posedge clk; peripherals sample on negedge, so all bus outputs must be glitch-free registers.

Parameters:
ADDR_W, 8, width of register address bus.
STROBE_CYC, 2, ds-low cycles per access when USE_DTACK=0; legal range 1..15.
USE_DTACK, 0, 1 = end strobe on bus_dtack instead of a fixed count.
TIMEOUT, 15, max strobe cycles waiting for bus_dtack before error; legal range 1..255.

Ports:
clk  in  1  system clock, all logic on rising edge.
reset  in  1  synchronous, active-high.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request this cycle.
req_write  in  1  1 = write, 0 = read.
req_addr  in  ADDR_W  target register address.
req_wdata  in  8  write data.
rsp_valid  out  1  one-cycle completion pulse, no backpressure.
rsp_rdata  out  8  read data, valid with rsp_valid; 0 for writes and errors.
rsp_err  out  1  timeout flag, valid with rsp_valid.
bus_addr  out  ADDR_W  address to peripheral decode.
bus_sel  out  1  peripheral select.
bus_ds  out  1  data strobe, active low.
bus_rw  out  1  1 = read, 0 = write.
bus_dout  out  8  write data to peripheral din.
bus_din  in  8  read data from peripheral dout; 0 when unselected.
bus_dtack  in  1  active-high acknowledge; ignored when USE_DTACK=0.

Behaviour:
- Reset state: IDLE. Output values:
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0
  - bus_sel=0, bus_ds=1, bus_rw=1, bus_addr=0, bus_dout=0
- Reset mid-operation: next edge forces the reset state. Aborted transaction produces no rsp_valid.
- req_ready = (state==IDLE). Combinational from state only, never from req_valid.
- Accept: rising edge with req_valid && req_ready.
  - Latch req_write, req_addr, req_wdata.
  - Inputs are don't-care at all other times.
- States:
  - IDLE: bus idle values. On accept -> SETUP.
  - SETUP (1 cycle): bus_sel=1, bus_ds=1, bus_addr=latched, bus_rw=~write, bus_dout=wdata (write) or 0 (read). -> STROBE.
  - STROBE: as SETUP but bus_ds=0. A 4-bit/8-bit cycle counter starts at 1 on entry.
    - USE_DTACK=0: leave after exactly STROBE_CYC cycles.
    - USE_DTACK=1: leave on the edge where bus_dtack=1 (minimum 1 cycle). If the counter reaches TIMEOUT with no dtack, leave with err=1.
    - Read data: capture bus_din on the leaving edge (0 on error).
    - -> HOLD.
  - HOLD (1 cycle): bus_ds=1, bus_sel=1, addr/rw/dout held. rsp_valid=1 with rsp_rdata/rsp_err. -> IDLE.
- rsp_valid is exactly one cycle per accepted request.
  - rsp_rdata and rsp_err keep their values until the next response.
  - rsp_rdata is forced to 0 for writes.
- Latency, fixed mode: accept edge to rsp_valid high = 2+STROBE_CYC cycles (4 at default).
- Back-to-back throughput: one request per 3+STROBE_CYC cycles. A new accept is possible on the edge ending the IDLE cycle after HOLD.
- A dtack asserted at the same edge as timeout is a success, not an error.
- A dtack outside STROBE is ignored.
- The bus never has ds low while sel is low. bus_rw and bus_addr are stable for the whole SETUP..HOLD window.

Test Plan:
- Write, default params, 8-bit config slave at addr 0x10: req_write=1, addr=0x10, wdata=0x03.
  - ds low for exactly 2 cycles with sel=1, rw=0, dout=0x03.
  - Slave config becomes 0x03.
  - rsp_valid 4 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read-back of the same register: rw=1 throughout. rsp_rdata=0x03, rsp_err=0.
- Busy behaviour: hold req_valid=1 with two requests queued by the bench.
  - req_ready=0 during SETUP/STROBE/HOLD.
  - Second request accepted 1 cycle after the first rsp_valid.
  - Exactly two rsp_valid pulses.
- USE_DTACK=1, TIMEOUT=4:
  - Read with dtack raised on 3rd strobe cycle and bus_din=0xA5 -> rsp_rdata=0xA5, rsp_err=0.
  - Read with dtack never raised -> ds low exactly 4 cycles, rsp_err=1, rsp_rdata=0.
- Reset asserted during STROBE of a write:
  - Next edge: sel=0, ds=1, rw=1, req_ready=1.
  - No rsp_valid for that transaction.
  - Slave retains its pre-write value unless a negedge sample occurred while ds was low.
